// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared helpers for the fifo_flex block
// Purpose: elaboration-time helper functions used for parameter legality checks.
// Ports: none (package).
package fifo_pkg;

   // True when v is a positive power of two.
   function automatic bit is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - simple dual-port storage array for fifo_flex
// Purpose: DATA_W x DEPTH RAM, one synchronous write port and one read port that is
//          registered (FWFT=0) or asynchronous (FWFT=1). Contents are never reset.
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-low reset (registered read data only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (registered mode)
//   raddr  in   read address
//   rdata  out  read data
module fifo_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16,
   parameter int FWFT   = 0,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   generate
      if (FWFT != 0) begin : g_async_rd
         // Head word is always presented; rd_ptr is a register so no path from rd.
         assign rdata = mem[raddr];
      end else begin : g_reg_rd
         // Read-before-write: a simultaneous write to the same slot (full FIFO with
         // wr&rd) returns the old word, which is the one being popped.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               rdata <= '0;
            end else if (re) begin
               rdata <= mem[raddr];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/fifo_flex.sv
// rtl/fifo_flex.sv - parametrised single-clock FIFO with flags, flush and error flags
// Purpose: pointers, fill count, registered status flags and sticky error flags around
//          a fifo_mem storage array; standard (registered) or FWFT read mode.
// Ports:
//   clk           in   rising-edge clock
//   rst           in   asynchronous active-low reset
//   clr           in   synchronous flush (empties FIFO, clears error flags)
//   wr / din      in   write request / write data
//   rd            in   read request (standard) or pop acknowledge (FWFT)
//   dout          out  read data
//   full, empty   out  count == DEPTH / count == 0
//   almost_full   out  count >= AF_LEVEL
//   almost_empty  out  count <= AE_LEVEL
//   count         out  entries stored
//   overflow      out  sticky: write rejected because full
//   underflow     out  sticky: read while empty
module fifo_flex
   import fifo_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2,
   parameter int FWFT     = 0,
   localparam int AW      = $clog2(DEPTH),
   localparam int PW      = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              wr,
   input  logic [DATA_W-1:0] din,
   input  logic              rd,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [PW-1:0]     count,
   output logic              overflow,
   output logic              underflow
);

   generate
      if (DATA_W < 1) begin : g_bad_width
         $error("fifo_flex: DATA_W must be >= 1");
      end
      if (DEPTH < 4 || !is_pow2(DEPTH)) begin : g_bad_depth
         $error("fifo_flex: DEPTH must be a power of 2 and >= 4");
      end
      if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
         $error("fifo_flex: AF_LEVEL must be within 1..DEPTH-1");
      end
      if (AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
         $error("fifo_flex: AE_LEVEL must be within 1..DEPTH-1");
      end
   endgenerate

   localparam logic [PW-1:0] AF_C = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_C = PW'(AE_LEVEL);

   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW-1:0]     wr_ptr_n, rd_ptr_n, cnt_n;
   logic              rd_ok, wr_ok;
   logic              full_n, empty_n;
   logic [DATA_W-1:0] mem_rdata;

   always_comb begin
      rd_ok    = rd && !empty;
      // A full FIFO still accepts a write when a read frees a slot in the same cycle.
      wr_ok    = wr && (!full || rd_ok);
      wr_ptr_n = wr_ptr + {{AW{1'b0}}, wr_ok};
      rd_ptr_n = rd_ptr + {{AW{1'b0}}, rd_ok};
      cnt_n    = count + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
      // Equal index with differing wrap bit means the writer lapped the reader.
      empty_n  = (wr_ptr_n == rd_ptr_n);
      full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                 (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else if (clr) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         wr_ptr       <= wr_ptr_n;
         rd_ptr       <= rd_ptr_n;
         count        <= cnt_n;
         full         <= full_n;
         empty        <= empty_n;
         almost_full  <= (cnt_n >= AF_C);
         almost_empty <= (cnt_n <= AE_C);
         if (wr && !wr_ok) begin
            overflow <= 1'b1;
         end
         if (rd && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .FWFT   (FWFT)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_ok && !clr),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (din),
      .re    (rd_ok && !clr),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (mem_rdata)
   );

   // In FWFT mode the array output is meaningless while empty; present zero so the
   // reset value of dout holds and stale words never look valid.
   assign dout = (FWFT != 0 && empty) ? '0 : mem_rdata;

endmodule

// File: tb/tb_fifo_flex.sv
// tb/tb_fifo_flex.sv - self-checking bench for fifo_flex (standard and FWFT instances)
module tb_fifo_flex;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = 14;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          clr = 1'b0;
   logic          wr  = 1'b0;
   logic          rd  = 1'b0;
   logic [DW-1:0] din = '0;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_full, s_empty, s_af, s_ae, s_ov, s_uf;
   logic          f_full, f_empty, f_af, f_ae, f_ov, f_uf;
   logic [4:0]    s_count, f_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fifo_flex #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
      .clk(clk), .rst(rst), .clr(clr), .wr(wr), .din(din), .rd(rd),
      .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
      .almost_empty(s_ae), .count(s_count), .overflow(s_ov), .underflow(s_uf)
   );

   fifo_flex #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
      .clk(clk), .rst(rst), .clr(clr), .wr(wr), .din(din), .rd(rd),
      .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
      .almost_empty(f_ae), .count(f_count), .overflow(f_ov), .underflow(f_uf)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain queue plus the last popped word.
   logic [DW-1:0] mq [$];
   logic [DW-1:0] m_dout;
   bit            m_ov, m_uf, m_ra, m_wa;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_ov   = 1'b0;
         m_uf   = 1'b0;
         m_dout = '0;
      end else if (clr) begin
         mq.delete();
         m_ov = 1'b0;
         m_uf = 1'b0;
      end else begin
         m_ra = rd && (mq.size() > 0);
         m_wa = wr && ((mq.size() < DEPTH) || m_ra);
         if (rd && mq.size() == 0) m_uf = 1'b1;
         if (wr && !m_wa) m_ov = 1'b1;
         if (m_ra) m_dout = mq.pop_front();
         if (m_wa) mq.push_back(din);
      end
   end

   // Compare process: every cycle, shortly after the active edge.
   always @(posedge clk) begin
      int n;
      #2;
      n = mq.size();
      chk("s_count", 32'(s_count), n);
      chk("s_full",  32'(s_full),  32'(n == DEPTH));
      chk("s_empty", 32'(s_empty), 32'(n == 0));
      chk("s_af",    32'(s_af),    32'(n >= AF));
      chk("s_ae",    32'(s_ae),    32'(n <= AE));
      chk("s_ov",    32'(s_ov),    32'(m_ov));
      chk("s_uf",    32'(s_uf),    32'(m_uf));
      chk("s_dout",  32'(s_dout),  32'(m_dout));
      chk("f_count", 32'(f_count), n);
      chk("f_empty", 32'(f_empty), 32'(n == 0));
      chk("f_full",  32'(f_full),  32'(n == DEPTH));
      chk("f_ov",    32'(f_ov),    32'(m_ov));
      chk("f_uf",    32'(f_uf),    32'(m_uf));
      chk("f_dout",  32'(f_dout),  (n > 0) ? 32'(mq[0]) : 32'h0);
   end

   task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
      @(negedge clk);
      wr  = w;
      din = d;
      rd  = r;
      clr = c;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_s_count"}, 32'(s_count), 0);
      chk({tag, "_s_empty"}, 32'(s_empty), 1);
      chk({tag, "_s_full"},  32'(s_full),  0);
      chk({tag, "_s_af"},    32'(s_af),    0);
      chk({tag, "_s_ae"},    32'(s_ae),    1);
      chk({tag, "_s_ov"},    32'(s_ov),    0);
      chk({tag, "_s_uf"},    32'(s_uf),    0);
      chk({tag, "_s_dout"},  32'(s_dout),  0);
      chk({tag, "_f_empty"}, 32'(f_empty), 1);
      chk({tag, "_f_count"}, 32'(f_count), 0);
      chk({tag, "_f_dout"},  32'(f_dout),  0);
   endtask

   initial begin
      // 1: reset held while inputs toggle
      for (int i = 0; i < 6; i++) begin
         cyc(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      end
      after_edge();
      chk_reset_vals("rst_hold");
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b1;
      after_edge();
      chk("rst_release_count", 32'(s_count), 0);
      chk("rst_release_uf", 32'(s_uf), 0);

      // 2: fill, overflow, ordered drain
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0);
         after_edge();
         if (i == 13) chk("fill_af_13", 32'(s_af), 0);
         if (i == 14) chk("fill_af_14", 32'(s_af), 1);
         if (i == 15) chk("fill_full_15", 32'(s_full), 0);
         if (i == 16) chk("fill_full_16", 32'(s_full), 1);
      end
      cyc(1'b1, 8'h77, 1'b0, 1'b0);
      after_edge();
      chk("ovf_flag", 32'(s_ov), 1);
      chk("ovf_count", 32'(s_count), 16);
      for (int i = 1; i <= 16; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         after_edge();
         chk("drain_data", 32'(s_dout), i);
      end
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      after_edge();
      chk("drain_empty", 32'(s_empty), 1);

      // 3: reads on empty, clr
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      after_edge();
      chk("rd_empty_uf", 32'(s_uf), 1);
      chk("rd_empty_count", 32'(s_count), 0);
      cyc(1'b1, 8'h3C, 1'b1, 1'b0);
      after_edge();
      chk("wrrd_empty_count", 32'(s_count), 1);
      chk("wrrd_empty_uf", 32'(s_uf), 1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      after_edge();
      chk("clr_ov", 32'(s_ov), 0);
      chk("clr_uf", 32'(s_uf), 0);
      chk("clr_count", 32'(s_count), 0);

      // 4: full with simultaneous wr&rd across wrap-around
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
      for (int k = 0; k < 20; k++) begin
         cyc(1'b1, 8'(8'h40 + k), 1'b1, 1'b0);
         after_edge();
         chk("full_wrrd_count", 32'(s_count), 16);
         chk("full_wrrd_ov", 32'(s_ov), 0);
         chk("full_wrrd_data", 32'(s_dout), (k < 16) ? (32'h20 + k) : (32'h40 + k - 16));
      end
      for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

      // 5: FWFT single word, no same-cycle bypass
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      #1;
      chk("fwft_pre_empty", 32'(f_empty), 1);
      after_edge();
      chk("fwft_dout", 32'(f_dout), 32'hA5);
      chk("fwft_empty", 32'(f_empty), 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      after_edge();
      chk("fwft_hold", 32'(f_dout), 32'hA5);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      after_edge();
      chk("fwft_pop_empty", 32'(f_empty), 1);

      // Randomised traffic in phases with different fill bias
      for (int ph = 0; ph < 15; ph++) begin
         int pw, pr;
         pw = $urandom_range(10, 90);
         pr = $urandom_range(10, 90);
         for (int k = 0; k < 200; k++) begin
            cyc($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
                $urandom_range(0, 63) == 0);
         end
      end

      // 6: asynchronous reset between edges during a burst
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      cyc(1'b1, 8'h70, 1'b1, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b1;
      after_edge();
      chk("post_rst_count", 32'(s_count), 0);

      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      after_edge();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
